fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Instruction-fetch controller in the IF stage. It owns the architectural fetch PC and issues single-outstanding read requests to the instruction-memory wrapper. It sequences PC advance, stalls on IM latency and DM busy, and handles branch/jump redirects (flush) that arrive while a fetch is in flight. It delivers one instruction per request to the IF/ID register; redirect always takes priority over stall.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC fetched first after reset.
- CNT_W, 32, width of performance counters.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- im_req  out  1  IM read request; level, held until im_gnt.
- im_addr  out  32  IM read address; stable while im_req=1.
- im_gnt  in  1  request accepted this cycle.
- im_rvalid  in  1  instruction data valid.
- im_rdata  in  32  instruction word.
- dm_busy  in  1  downstream memory-stage stall.
- redirect  in  1  taken branch/jump or flush resolved in EX.
- redirect_pc  in  32  redirect target; bits [1:0] forced to 0 internally.
- if_valid  out  1  instruction presented to IF/ID.
- if_pc  out  32  PC of presented instruction.
- if_inst  out  32  presented instruction.
- cnt_stall  out  CNT_W  stall-cycle counter.
- cnt_flush  out  CNT_W  accepted-redirect counter.

## Operation
- FSM states: IDLE, REQ, WAIT, KILL, HOLD. Registers: pc, pend_pc, hold_inst.
- IDLE: one cycle after reset. Goes to REQ. A redirect in IDLE loads pc. im_rvalid is ignored.
- REQ: im_req=1, im_addr=pc.
  - im_gnt → WAIT.
  - A redirect in REQ latches pend_pc and does not change im_addr. On im_gnt the FSM goes to KILL instead of WAIT.
  - With redirect and no grant, the FSM stays in REQ with a kill flag set. Grant then goes to KILL.
- WAIT, im_rvalid=1, redirect=0: if_valid=1, if_pc=pc, if_inst=im_rdata.
  - dm_busy=0: instruction consumed; pc←pc+4; → REQ.
  - dm_busy=1: hold_inst←im_rdata; → HOLD.
- WAIT, redirect=1: an im_rvalid in the same cycle is discarded and pc←redirect_pc, then → REQ. Without im_rvalid, pend_pc←redirect_pc and → KILL.
- KILL: wait for im_rvalid. Discard the data, pc←pend_pc, → REQ. A later redirect in KILL overwrites pend_pc (latest wins).
- HOLD: if_valid=1, if_inst=hold_inst.
  - dm_busy=0: consumed; pc←pc+4; → REQ.
  - redirect=1: held instruction dropped, if_valid=0 that cycle; pc←redirect_pc; → REQ.
- Arithmetic: pc+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- Only one request is outstanding. im_req is never asserted in WAIT, KILL or HOLD.

## Timing
- Reset values: state=IDLE, pc=RESET_PC, im_req=0, if_valid=0, if_pc=0, if_inst=0, counters=0.
- Reset asserted mid-transaction abandons the fetch. A stale im_rvalid after reset is ignored in IDLE.
- if_valid, if_pc and if_inst are combinational from state, im_rvalid and hold_inst. All other state is registered.
- Best case: grant in cycle N, rvalid in N+1 gives if_valid in N+1 and the next im_req in N+2. Peak rate is 1 instruction per 2 cycles.
- After a redirect, the first im_req to the target occurs in the cycle after the redirect is acted on (WAIT+rvalid, HOLD, IDLE), or after the killed response returns (KILL).

## Configuration
- FETCH_CTRL_PERF_EN defined:
  - cnt_stall increments each cycle in HOLD with dm_busy=1 or in REQ with im_gnt=0.
  - cnt_flush increments each cycle redirect=1 outside reset.
  - Both counters saturate at all-ones.
- Not defined: both counter ports are tied to 0 and no counter flops are built.

## Structure
- fetch_ctrl_pkg holds:
  - fetch_state_e enum (IDLE, REQ, WAIT, KILL, HOLD).
  - PC_INC=32'd4.
  - RESET_PC_DEFAULT constant.
- Sub-module fetch_ctrl_perf holds the saturating counters and is instantiated only under FETCH_CTRL_PERF_EN.

## Test plan
- Reset release, im_gnt immediate, im_rvalid one cycle later with rdata=32'h0000_0013 → im_addr=0 then 4. if_valid pulses with if_pc=0, if_pc=4.
- dm_busy=1 for 3 cycles when rvalid arrives at pc=8 → if_valid held 4 cycles with constant if_inst. pc advances to 12 only after dm_busy falls. No im_req during the hold.
- redirect to 32'h0000_0102 in WAIT, rvalid 2 cycles later → that instruction is never presented. The next im_addr is 32'h0000_0100.
- redirect to 0x40 then 0x80 on consecutive KILL cycles → only 0x80 is fetched. cnt_flush=2 with FETCH_CTRL_PERF_EN.
- redirect in the same cycle as rvalid and dm_busy=1 → no if_valid. im_req to redirect_pc the next cycle.
- pc=32'hFFFF_FFFC delivered → next im_addr=0. rst_n pulled low during WAIT → im_req=0 and pc=RESET_PC immediately. A stale rvalid is ignored.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the IF-stage fetch controller.
package fetch_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        KILL,
        HOLD
    } fetch_state_e;

    localparam logic [31:0] PC_INC           = 32'd4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Instruction addresses are word aligned; low two bits are dropped.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_ctrl_perf.sv
// Saturating stall / flush event counters for the fetch controller.
module fetch_ctrl_perf #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_stall_inc,
    input  logic             i_flush_inc,
    output logic [CNT_W-1:0] o_cnt_stall,
    output logic [CNT_W-1:0] o_cnt_flush
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt_stall;
    logic [CNT_W-1:0] r_cnt_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_stall <= '0;
            r_cnt_flush <= '0;
        end else begin
            if (i_stall_inc && (r_cnt_stall != '1))
                r_cnt_stall <= r_cnt_stall + CNT_ONE;
            if (i_flush_inc && (r_cnt_flush != '1))
                r_cnt_flush <= r_cnt_flush + CNT_ONE;
        end
    end

    assign o_cnt_stall = r_cnt_stall;
    assign o_cnt_flush = r_cnt_flush;

endmodule

// File: rtl/fetch_ctrl.sv
// IF-stage fetch controller: single-outstanding IM requests, stall and redirect handling.
// Define FETCH_CTRL_PERF_EN to build the stall/flush performance counters.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             im_req,
    output logic [31:0]      im_addr,
    input  logic             im_gnt,
    input  logic             im_rvalid,
    input  logic [31:0]      im_rdata,
    input  logic             dm_busy,
    input  logic             redirect,
    input  logic [31:0]      redirect_pc,
    output logic             if_valid,
    output logic [31:0]      if_pc,
    output logic [31:0]      if_inst,
    output logic [CNT_W-1:0] cnt_stall,
    output logic [CNT_W-1:0] cnt_flush
);

    fetch_state_e r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_pend_pc;
    logic [31:0]  r_hold_inst;
    logic         r_kill;
    logic         r_im_req;

    logic [31:0]  w_tgt;
    logic [31:0]  w_pc_inc;
    logic         w_if_valid;
    logic [31:0]  w_if_inst;

    assign w_tgt    = align_pc(redirect_pc);
    assign w_pc_inc = r_pc + PC_INC;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_pc        <= RESET_PC;
            r_pend_pc   <= RESET_PC;
            r_hold_inst <= '0;
            r_kill      <= 1'b0;
            r_im_req    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (redirect)
                        r_pc <= w_tgt;
                    r_state  <= REQ;
                    r_im_req <= 1'b1;
                end
                REQ: begin
                    // im_addr stays put; a redirect only decides the fate of the response.
                    if (redirect)
                        r_pend_pc <= w_tgt;
                    if (im_gnt) begin
                        r_im_req <= 1'b0;
                        r_kill   <= 1'b0;
                        r_state  <= (r_kill || redirect) ? KILL : WAIT;
                    end else if (redirect) begin
                        r_kill <= 1'b1;
                    end
                end
                WAIT: begin
                    if (redirect) begin
                        if (im_rvalid) begin
                            r_pc     <= w_tgt;
                            r_state  <= REQ;
                            r_im_req <= 1'b1;
                        end else begin
                            r_pend_pc <= w_tgt;
                            r_state   <= KILL;
                        end
                    end else if (im_rvalid) begin
                        if (dm_busy) begin
                            r_hold_inst <= im_rdata;
                            r_state     <= HOLD;
                        end else begin
                            r_pc     <= w_pc_inc;
                            r_state  <= REQ;
                            r_im_req <= 1'b1;
                        end
                    end
                end
                KILL: begin
                    // A redirect landing with the killed response still wins.
                    if (im_rvalid) begin
                        r_pc     <= redirect ? w_tgt : r_pend_pc;
                        r_state  <= REQ;
                        r_im_req <= 1'b1;
                    end else if (redirect) begin
                        r_pend_pc <= w_tgt;
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        r_pc     <= w_tgt;
                        r_state  <= REQ;
                        r_im_req <= 1'b1;
                    end else if (!dm_busy) begin
                        r_pc     <= w_pc_inc;
                        r_state  <= REQ;
                        r_im_req <= 1'b1;
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_im_req <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        w_if_valid = 1'b0;
        w_if_inst  = '0;
        case (r_state)
            WAIT: begin
                if (im_rvalid && !redirect) begin
                    w_if_valid = 1'b1;
                    w_if_inst  = im_rdata;
                end
            end
            HOLD: begin
                if (!redirect) begin
                    w_if_valid = 1'b1;
                    w_if_inst  = r_hold_inst;
                end
            end
            default: ;
        endcase
    end

    assign im_req   = r_im_req;
    assign im_addr  = r_pc;
    assign if_valid = w_if_valid;
    assign if_pc    = w_if_valid ? r_pc : '0;
    assign if_inst  = w_if_inst;

`ifdef FETCH_CTRL_PERF_EN
    logic w_stall_inc;
    logic w_flush_inc;

    assign w_stall_inc = ((r_state == HOLD) && dm_busy) || ((r_state == REQ) && !im_gnt);
    assign w_flush_inc = redirect;

    fetch_ctrl_perf #(
        .CNT_W(CNT_W)
    ) u_perf (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_stall_inc (w_stall_inc),
        .i_flush_inc (w_flush_inc),
        .o_cnt_stall (cnt_stall),
        .o_cnt_flush (cnt_flush)
    );
`else
    assign cnt_stall = '0;
    assign cnt_flush = '0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios with literal checks, then random IM/DM/redirect traffic against a transaction-level model.
module tb_fetch_ctrl;

    localparam logic [31:0] RPC   = 32'h0000_0000;
    localparam int          CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             im_req;
    logic [31:0]      im_addr;
    logic             im_gnt = 1'b0;
    logic             im_rvalid = 1'b0;
    logic [31:0]      im_rdata = '0;
    logic             dm_busy = 1'b0;
    logic             redirect = 1'b0;
    logic [31:0]      redirect_pc = '0;
    logic             if_valid;
    logic [31:0]      if_pc;
    logic [31:0]      if_inst;
    logic [CNT_W-1:0] cnt_stall;
    logic [CNT_W-1:0] cnt_flush;

    always #5 clk = ~clk;

    fetch_ctrl #(.RESET_PC(RPC), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .im_req(im_req), .im_addr(im_addr), .im_gnt(im_gnt),
        .im_rvalid(im_rvalid), .im_rdata(im_rdata),
        .dm_busy(dm_busy), .redirect(redirect), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
        .cnt_stall(cnt_stall), .cnt_flush(cnt_flush)
    );

    int vectors = 0;
    int errs    = 0;

    // Transaction view of the fetcher: what is being asked for, what is in flight,
    // whether the in-flight word is doomed, and what is parked for a busy DM stage.
    bit               m_boot, m_req, m_out, m_drop, m_held;
    logic [31:0]      m_pc, m_tgt, m_hinst;
    logic [CNT_W-1:0] m_stall, m_flush;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %08h want %08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_boot = 1; m_req = 0; m_out = 0; m_drop = 0; m_held = 0;
        m_pc = RPC; m_tgt = RPC; m_hinst = '0;
        m_stall = '0; m_flush = '0;
    endtask

    function automatic bit exp_valid();
        return !redirect && ((m_out && !m_drop && im_rvalid) || m_held);
    endfunction

    task automatic compare();
        bit ev;
        ev = exp_valid();
        vectors++;
        chk("im_req", im_req, m_req);
        if (m_req) chk("im_addr", im_addr, m_pc);
        chk("if_valid", if_valid, ev);
        if (ev) begin
            chk("if_pc", if_pc, m_pc);
            chk("if_inst", if_inst, m_held ? m_hinst : im_rdata);
        end
`ifdef FETCH_CTRL_PERF_EN
        chk("cnt_stall", cnt_stall, m_stall);
        chk("cnt_flush", cnt_flush, m_flush);
`else
        chk("cnt_stall", cnt_stall, '0);
        chk("cnt_flush", cnt_flush, '0);
`endif
    endtask

    task automatic model_update();
        logic [31:0] t;
        t = redirect_pc & 32'hFFFF_FFFC;
        if (((m_held && dm_busy) || (m_req && !im_gnt)) && m_stall != '1) m_stall++;
        if (redirect && m_flush != '1) m_flush++;
        if (m_boot) begin
            m_boot = 0;
            if (redirect) m_pc = t;
            m_req = 1;
        end else if (m_req) begin
            if (redirect) begin m_drop = 1; m_tgt = t; end
            if (im_gnt) begin m_req = 0; m_out = 1; end
        end else if (m_out) begin
            if (m_drop) begin
                if (im_rvalid) begin
                    m_out = 0; m_drop = 0; m_req = 1;
                    m_pc = redirect ? t : m_tgt;
                end else if (redirect) m_tgt = t;
            end else if (redirect) begin
                if (im_rvalid) begin m_out = 0; m_pc = t; m_req = 1; end
                else begin m_drop = 1; m_tgt = t; end
            end else if (im_rvalid) begin
                m_out = 0;
                if (dm_busy) begin m_held = 1; m_hinst = im_rdata; end
                else begin m_pc = m_pc + 32'd4; m_req = 1; end
            end
        end else if (m_held) begin
            if (redirect) begin m_held = 0; m_pc = t; m_req = 1; end
            else if (!dm_busy) begin m_held = 0; m_pc = m_pc + 32'd4; m_req = 1; end
        end
    endtask

    task automatic step();
        @(negedge clk);
        compare();
        @(posedge clk);
        if (rst_n) model_update();
        #1;
    endtask

    task automatic drv(input bit g, input bit v, input logic [31:0] d,
                       input bit b, input bit r, input logic [31:0] rp);
        im_gnt = g; im_rvalid = v; im_rdata = d; dm_busy = b;
        redirect = r; redirect_pc = rp;
    endtask

    initial begin
        bit          pend, g, v, b, r, stale;
        int          lat, rcyc;
        logic [31:0] rp;

        // reset state
        rst_n = 0; model_reset();
        drv(0, 0, 0, 0, 0, 0); #1;
        chk("rst im_req", im_req, 0); chk("rst if_valid", if_valid, 0);
        chk("rst if_pc", if_pc, 0); chk("rst if_inst", if_inst, 0);
        chk("rst cnt_stall", cnt_stall, 0); chk("rst cnt_flush", cnt_flush, 0);
        chk("rst pc", im_addr, RPC);
        step(); step();
        rst_n = 1;
        drv(0, 1, 32'hBAD0_0000, 0, 0, 0); #1;
        chk("idle stale rvalid", if_valid, 0);
        step();

        // back-to-back fetches at 0 and 4
        drv(1, 0, 0, 0, 0, 0); #1;
        chk("req0", im_req, 1); chk("addr0", im_addr, 32'h0);
        step();
        drv(0, 1, 32'h0000_0013, 0, 0, 0); #1;
        chk("v0", if_valid, 1); chk("pc0", if_pc, 32'h0); chk("inst0", if_inst, 32'h13);
        step();
        drv(1, 0, 0, 0, 0, 0); #1; chk("addr4", im_addr, 32'h4); step();
        drv(0, 1, 32'h0000_0013, 0, 0, 0); #1; chk("pc4", if_pc, 32'h4); step();

        // DM stall for three cycles on the word at 8
        drv(1, 0, 0, 0, 0, 0); #1; chk("addr8", im_addr, 32'h8); step();
        drv(0, 1, 32'hDEAD_0008, 1, 0, 0); #1; chk("hold v1", if_valid, 1); step();
        for (int i = 0; i < 3; i++) begin
            drv(0, 0, 32'h1111_1111, (i < 2), 0, 0); #1;
            chk("hold valid", if_valid, 1); chk("hold inst", if_inst, 32'hDEAD_0008);
            chk("hold pc", if_pc, 32'h8); chk("hold noreq", im_req, 0);
            step();
        end
        drv(0, 0, 0, 0, 0, 0); #1; chk("addr12", im_addr, 32'hC); chk("req12", im_req, 1);

        // redirect in WAIT, response returns two cycles later and is dropped
        drv(1, 0, 0, 0, 0, 0); step();
        drv(0, 0, 0, 0, 1, 32'h0000_0102); step();
        drv(0, 0, 0, 0, 0, 0); step();
        drv(0, 1, 32'hBAD0_000C, 0, 0, 0); #1; chk("kill drop", if_valid, 0); step();
        drv(0, 0, 0, 0, 0, 0); #1; chk("addr102", im_addr, 32'h100); chk("req102", im_req, 1);

        // consecutive redirects while killing: latest target wins
        drv(1, 0, 0, 0, 0, 0); step();
        drv(0, 0, 0, 0, 1, 32'h200); step();
        drv(0, 0, 0, 0, 1, 32'h40); step();
        drv(0, 0, 0, 0, 1, 32'h80); step();
        drv(0, 1, 32'hBAD0_0100, 0, 0, 0); #1; chk("kill2 drop", if_valid, 0); step();
        drv(0, 0, 0, 0, 0, 0); #1; chk("addr80", im_addr, 32'h80);

        // redirect together with rvalid and dm_busy
        drv(1, 0, 0, 0, 0, 0); step();
        drv(0, 1, 32'hBAD0_0080, 1, 1, 32'h300); #1; chk("redir+rv", if_valid, 0); step();
        drv(0, 0, 0, 0, 0, 0); #1; chk("req300", im_req, 1); chk("addr300", im_addr, 32'h300);

        // wrap at top of address space
        drv(1, 0, 0, 0, 1, 32'hFFFF_FFFF); step();
        drv(0, 1, 32'hBAD0_0300, 0, 0, 0); step();
        drv(1, 0, 0, 0, 0, 0); #1; chk("addrFFC", im_addr, 32'hFFFF_FFFC); step();
        drv(0, 1, 32'h0000_0067, 0, 0, 0); #1; chk("pcFFC", if_pc, 32'hFFFF_FFFC); step();
        drv(1, 0, 0, 0, 0, 0); #1; chk("wrap addr", im_addr, 32'h0); step();
        drv(0, 1, 32'h0000_0013, 0, 0, 0); step();
        drv(1, 0, 0, 0, 0, 0); #1; chk("addr4b", im_addr, 32'h4); step();

        // reset mid-WAIT, stale response arrives during and after reset
        rst_n = 0; model_reset();
        drv(0, 1, 32'hBAD0_0004, 0, 0, 0); #1;
        chk("mid rst req", im_req, 0); chk("mid rst pc", im_addr, RPC); chk("mid rst v", if_valid, 0);
        step();
        rst_n = 1; #1; chk("stale idle", if_valid, 0); step();
        drv(0, 0, 0, 0, 0, 0); #1; chk("post rst addr", im_addr, RPC); chk("post rst req", im_req, 1);

        // random traffic
        pend = 0; lat = 0; rcyc = 0; stale = 0;
        for (int n = 0; n < 4000; n++) begin
            if (rst_n && ($urandom % 600 == 0)) begin
                rst_n = 0; model_reset(); pend = 0; rcyc = 2;
            end
            g = rst_n && im_req && ($urandom % 3 != 0);
            if (!rst_n || stale) v = $urandom % 2;
            else                 v = pend && (lat == 0);
            b = ($urandom % 3 == 0);
            r = ($urandom % 7 == 0);
            rp = ($urandom % 4 == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom;
            drv(g, v, $urandom, b, r, rp);
            step();
            stale = 0;
            if (!rst_n) begin
                pend = 0;
                rcyc--;
                if (rcyc == 0) begin rst_n = 1; stale = 1; end
            end else begin
                if (v) pend = 0;
                else if (pend && lat > 0) lat--;
                if (g) begin pend = 1; lat = $urandom_range(0, 2); end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
